// File: rtl/estacao_reserva.sv
`default_nettype none
// ============================================================================
//  Module      : estacao_reserva
//  Description : Reservation station for one functional unit of the
//                Tomasulo core. Accepts issued instructions with operand
//                values or producer tags, snoops the CDB to capture pending
//                operands, and dispatches the oldest ready entry to the
//                functional unit through a pulse + one-cycle WAIT handshake.
//  Optional    : RS_CDB_BYPASS_EN - when defined, an issuing operand whose
//                producer is broadcasting on the CDB in the same cycle
//                captures the broadcast value directly. When undefined,
//                issue is refused while the CDB is active.
//  Ports       : i_clock/i_reset        clock, async active-high reset
//                i_issue_*              issue request, instruction, Vj/Vk, Qj/Qk
//                o_issue_ready/o_issue_tag  free-entry flag, tag of next issue
//                i_cdb_*                common data bus broadcast
//                i_fu_disponivel        functional unit available
//                o_fu_*                 registered dispatch pulse and payload
//                o_busy_count           occupied entries
//  Revision    : 1.0 - initial release
// ============================================================================
module estacao_reserva #(
    parameter int NUM_ENTRIES = 3,
    parameter int TAG_BASE    = 1
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_issue_valid,
    output logic        o_issue_ready,
    input  logic [15:0] i_issue_inst,
    input  logic [15:0] i_issue_vj,
    input  logic [15:0] i_issue_vk,
    input  logic [2:0]  i_issue_qj,
    input  logic [2:0]  i_issue_qk,
    output logic [2:0]  o_issue_tag,
    input  logic        i_cdb_valid,
    input  logic [2:0]  i_cdb_tag,
    input  logic [15:0] i_cdb_data,
    input  logic        i_fu_disponivel,
    output logic        o_fu_instruct_in,
    output logic [15:0] o_fu_instruction,
    output logic [2:0]  o_fu_code_in,
    output logic [15:0] o_fu_reg2,
    output logic [15:0] o_fu_reg1,
    output logic [2:0]  o_busy_count
);

    localparam logic [2:0] c_TAG_BASE = 3'(TAG_BASE);
    localparam logic [2:0] c_AGE_MAX  = 3'(NUM_ENTRIES - 1);

    localparam logic [0:0] c_S_IDLE = 1'b0;
    localparam logic [0:0] c_S_WAIT = 1'b1;

    // Entry storage
    logic        r_busy [NUM_ENTRIES];
    logic [15:0] r_inst [NUM_ENTRIES];
    logic [15:0] r_vj   [NUM_ENTRIES];
    logic [15:0] r_vk   [NUM_ENTRIES];
    logic [2:0]  r_qj   [NUM_ENTRIES];
    logic [2:0]  r_qk   [NUM_ENTRIES];
    logic [2:0]  r_age  [NUM_ENTRIES];

    logic [0:0]  r_state;
    logic [0:0]  w_state_next;

    logic        w_free_found;
    logic [2:0]  w_free_idx;
    logic        w_issue_fire;
    logic        w_cdb_hit;
    logic        w_byp_j;
    logic        w_byp_k;

    logic        w_sel_found;
    logic [2:0]  w_sel_idx;
    logic [2:0]  w_sel_age;
    logic [15:0] w_sel_inst;
    logic [15:0] w_sel_vj;
    logic [15:0] w_sel_vk;
    logic        w_dispatch;
    logic [2:0]  w_count;

    // ------------------------------------------------------------------
    // Issue side: lowest free entry, from registered busy bits only
    // ------------------------------------------------------------------
    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = 3'd0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (!r_busy[i]) begin
                w_free_found = 1'b1;
                w_free_idx   = 3'(i);
            end
        end
    end

    assign w_cdb_hit = i_cdb_valid && (i_cdb_tag != 3'd0);

`ifdef RS_CDB_BYPASS_EN
    assign o_issue_ready = w_free_found;
    assign w_byp_j       = w_cdb_hit && (i_issue_qj == i_cdb_tag);
    assign w_byp_k       = w_cdb_hit && (i_issue_qk == i_cdb_tag);
`else
    // Without the bypass an issuing operand could miss a broadcast that
    // is on the bus right now, so issue is held off while the CDB is busy.
    assign o_issue_ready = w_free_found && !i_cdb_valid;
    assign w_byp_j       = 1'b0;
    assign w_byp_k       = 1'b0;
`endif

    assign o_issue_tag  = c_TAG_BASE + w_free_idx;
    assign w_issue_fire = i_issue_valid && o_issue_ready;

    // ------------------------------------------------------------------
    // Ready selection: oldest ready entry; equal (saturated) ages resolve
    // to the lowest index.
    // ------------------------------------------------------------------
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = 3'd0;
        w_sel_age   = 3'd0;
        w_sel_inst  = 16'd0;
        w_sel_vj    = 16'd0;
        w_sel_vk    = 16'd0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (r_busy[i] && (r_qj[i] == 3'd0) && (r_qk[i] == 3'd0) &&
                (!w_sel_found || (r_age[i] > w_sel_age))) begin
                w_sel_found = 1'b1;
                w_sel_idx   = 3'(i);
                w_sel_age   = r_age[i];
                w_sel_inst  = r_inst[i];
                w_sel_vj    = r_vj[i];
                w_sel_vk    = r_vk[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Dispatch FSM: state register / next-state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_S_IDLE: if (i_fu_disponivel && w_sel_found) w_state_next = c_S_WAIT;
            c_S_WAIT: w_state_next = c_S_IDLE;
            default:  w_state_next = c_S_IDLE;
        endcase
    end

    // The WAIT cycle never dispatches, independent of i_fu_disponivel,
    // because the unit may re-assert availability on the accepting edge.
    always_comb begin
        w_dispatch = 1'b0;
        case (r_state)
            c_S_IDLE: w_dispatch = i_fu_disponivel && w_sel_found;
            default:  w_dispatch = 1'b0;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            o_fu_instruct_in <= 1'b0;
            o_fu_instruction <= 16'd0;
            o_fu_code_in     <= 3'd0;
            o_fu_reg2        <= 16'd0;
            o_fu_reg1        <= 16'd0;
        end else begin
            o_fu_instruct_in <= w_dispatch;
            if (w_dispatch) begin
                o_fu_instruction <= w_sel_inst;
                o_fu_code_in     <= c_TAG_BASE + w_sel_idx;
                o_fu_reg2        <= w_sel_vj;
                o_fu_reg1        <= w_sel_vk;
            end
        end
    end

    // ------------------------------------------------------------------
    // Entry update: snoop, aging, dispatch free, issue write
    // ------------------------------------------------------------------
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                r_busy[i] <= 1'b0;
                r_inst[i] <= 16'd0;
                r_vj[i]   <= 16'd0;
                r_vk[i]   <= 16'd0;
                r_qj[i]   <= 3'd0;
                r_qk[i]   <= 3'd0;
                r_age[i]  <= 3'd0;
            end
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (r_busy[i]) begin
                    if (w_cdb_hit && (r_qj[i] == i_cdb_tag)) begin
                        r_vj[i] <= i_cdb_data;
                        r_qj[i] <= 3'd0;
                    end
                    if (w_cdb_hit && (r_qk[i] == i_cdb_tag)) begin
                        r_vk[i] <= i_cdb_data;
                        r_qk[i] <= 3'd0;
                    end
                    if (w_issue_fire && (r_age[i] != c_AGE_MAX)) begin
                        r_age[i] <= r_age[i] + 3'd1;
                    end
                end
                if (w_dispatch && (w_sel_idx == 3'(i))) begin
                    r_busy[i] <= 1'b0;
                end
                // The target entry is free in registered state, so this
                // never collides with the snoop or dispatch updates above.
                if (w_issue_fire && (w_free_idx == 3'(i))) begin
                    r_busy[i] <= 1'b1;
                    r_inst[i] <= i_issue_inst;
                    r_vj[i]   <= w_byp_j ? i_cdb_data : i_issue_vj;
                    r_vk[i]   <= w_byp_k ? i_cdb_data : i_issue_vk;
                    r_qj[i]   <= w_byp_j ? 3'd0 : i_issue_qj;
                    r_qk[i]   <= w_byp_k ? 3'd0 : i_issue_qk;
                    r_age[i]  <= 3'd0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Occupancy
    // ------------------------------------------------------------------
    always_comb begin
        w_count = 3'd0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (r_busy[i]) w_count = w_count + 3'd1;
        end
    end

    assign o_busy_count = w_count;

endmodule
`default_nettype wire

// File: tb/tb_estacao_reserva.sv
`default_nettype none
// ============================================================================
//  Module      : tb_estacao_reserva
//  Description : Self-checking bench for estacao_reserva. A behavioural
//                model of the station is checked against the DUT on every
//                falling edge; directed scenarios add literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_estacao_reserva;

    localparam int NE = 3;
    localparam int TB = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        issue_valid = 1'b0;
    logic [15:0] issue_inst = '0, issue_vj = '0, issue_vk = '0;
    logic [2:0]  issue_qj = '0, issue_qk = '0;
    logic        cdb_valid = 1'b0;
    logic [2:0]  cdb_tag = '0;
    logic [15:0] cdb_data = '0;
    logic        fu_disp = 1'b0;

    logic        issue_ready;
    logic [2:0]  issue_tag;
    logic        fu_pulse;
    logic [15:0] fu_inst, fu_reg2, fu_reg1;
    logic [2:0]  fu_code, busy_count;

    int checks = 0;
    int errors = 0;

    estacao_reserva #(.NUM_ENTRIES(NE), .TAG_BASE(TB)) dut (
        .i_clock          (clk),
        .i_reset          (rst),
        .i_issue_valid    (issue_valid),
        .o_issue_ready    (issue_ready),
        .i_issue_inst     (issue_inst),
        .i_issue_vj       (issue_vj),
        .i_issue_vk       (issue_vk),
        .i_issue_qj       (issue_qj),
        .i_issue_qk       (issue_qk),
        .o_issue_tag      (issue_tag),
        .i_cdb_valid      (cdb_valid),
        .i_cdb_tag        (cdb_tag),
        .i_cdb_data       (cdb_data),
        .i_fu_disponivel  (fu_disp),
        .o_fu_instruct_in (fu_pulse),
        .o_fu_instruction (fu_inst),
        .o_fu_code_in     (fu_code),
        .o_fu_reg2        (fu_reg2),
        .o_fu_reg1        (fu_reg1),
        .o_busy_count     (busy_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: one record per entry, outputs from spec rules
    // ------------------------------------------------------------------
    typedef struct {
        bit          busy;
        logic [15:0] inst, vj, vk;
        logic [2:0]  qj, qk;
        int          age;
    } ent_t;

    ent_t        m [NE];
    ent_t        n [NE];
    bit          m_wait;
    logic        m_pulse;
    logic [15:0] m_inst, m_r2, m_r1;
    logic [2:0]  m_code;

    always @(negedge clk) begin
        int  fi, si, cnt;
        bit  acc, disp, rdy;
        if (rst) begin
            for (int i = 0; i < NE; i++) begin
                m[i].busy = 0; m[i].inst = 0; m[i].vj = 0; m[i].vk = 0;
                m[i].qj = 0; m[i].qk = 0; m[i].age = 0;
            end
            m_wait = 0; m_pulse = 0; m_inst = 0; m_r2 = 0; m_r1 = 0; m_code = 0;
        end
        fi = -1; cnt = 0;
        for (int i = NE - 1; i >= 0; i--) if (!m[i].busy) fi = i;
        for (int i = 0; i < NE; i++) if (m[i].busy) cnt++;
`ifdef RS_CDB_BYPASS_EN
        rdy = (fi >= 0);
`else
        rdy = (fi >= 0) && !cdb_valid;
`endif
        chk("issue_ready", issue_ready, rdy);
        if (fi >= 0) chk("issue_tag", issue_tag, TB + fi);
        chk("busy_count", busy_count, cnt);
        chk("fu_instruct_in", fu_pulse, m_pulse);
        chk("fu_instruction", fu_inst, m_inst);
        chk("fu_code_in", fu_code, m_code);
        chk("fu_reg2", fu_reg2, m_r2);
        chk("fu_reg1", fu_reg1, m_r1);
        if (!rst) begin
            acc = issue_valid && rdy;
            si = -1;
            for (int i = 0; i < NE; i++)
                if (m[i].busy && m[i].qj == 0 && m[i].qk == 0 && (si < 0 || m[i].age > m[si].age))
                    si = i;
            disp = !m_wait && fu_disp && (si >= 0);
            n = m;
            for (int i = 0; i < NE; i++) begin
                if (m[i].busy && cdb_valid && cdb_tag != 0) begin
                    if (m[i].qj == cdb_tag) begin n[i].vj = cdb_data; n[i].qj = 0; end
                    if (m[i].qk == cdb_tag) begin n[i].vk = cdb_data; n[i].qk = 0; end
                end
                if (m[i].busy && acc) n[i].age = (m[i].age + 1 > NE - 1) ? NE - 1 : m[i].age + 1;
            end
            m_pulse = disp;
            if (disp) begin
                m_inst = m[si].inst; m_r2 = m[si].vj; m_r1 = m[si].vk;
                m_code = 3'(TB + si);
                n[si].busy = 0;
            end
            m_wait = disp;
            if (acc) begin
                n[fi].busy = 1; n[fi].inst = issue_inst; n[fi].age = 0;
                n[fi].vj = issue_vj; n[fi].qj = issue_qj;
                n[fi].vk = issue_vk; n[fi].qk = issue_qk;
`ifdef RS_CDB_BYPASS_EN
                if (cdb_valid && cdb_tag != 0 && issue_qj == cdb_tag) begin n[fi].vj = cdb_data; n[fi].qj = 0; end
                if (cdb_valid && cdb_tag != 0 && issue_qk == cdb_tag) begin n[fi].vk = cdb_data; n[fi].qk = 0; end
`endif
            end
            m = n;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [15:0] inst, input logic [15:0] vj, input logic [2:0] qj,
                         input logic [15:0] vk, input logic [2:0] qk);
        issue_valid = 1'b1; issue_inst = inst;
        issue_vj = vj; issue_qj = qj; issue_vk = vk; issue_qk = qk;
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        chk("rst busy_count", busy_count, 0);
        chk("rst issue_ready", issue_ready, 1);
        chk("rst issue_tag", issue_tag, 1);
        chk("rst pulse", fu_pulse, 0);
        chk("rst reg2", fu_reg2, 0);
        step();
        rst = 1'b0;

        // ADD with ready operands
        fu_disp = 1'b1;
        issue(16'h0000, 16'd5, 3'd0, 16'd3, 3'd0);
        @(negedge clk); chk("add ready", issue_ready, 1); chk("add tag", issue_tag, 1);
        step(); issue_valid = 1'b0;
        @(negedge clk); chk("add busy", busy_count, 1); chk("add nopulse", fu_pulse, 0);
        step();
        @(negedge clk);
        chk("add pulse", fu_pulse, 1); chk("add code", fu_code, 1);
        chk("add reg2", fu_reg2, 5); chk("add reg1", fu_reg1, 3);
        step();
        @(negedge clk); chk("add wait", fu_pulse, 0); chk("add hold reg2", fu_reg2, 5);
        step();

        // SUB waiting on tag 2
        issue(16'h0001, 16'hDEAD, 3'd2, 16'd4, 3'd0);
        step(); issue_valid = 1'b0;
        @(negedge clk); chk("sub stalled", fu_pulse, 0);
        step(); cdb_valid = 1'b1; cdb_tag = 3'd2; cdb_data = 16'd9;
        step(); cdb_valid = 1'b0;
        @(negedge clk); chk("sub not yet", fu_pulse, 0);
        step();
        @(negedge clk);
        chk("sub pulse", fu_pulse, 1); chk("sub reg2", fu_reg2, 9);
        chk("sub reg1", fu_reg1, 4); chk("sub inst", fu_inst, 16'h0001);
        step(); step();

        // Fill, hold with unit busy, then drain oldest first
        fu_disp = 1'b0;
        for (int k = 0; k < 3; k++) begin
            issue(16'h0010 + 16'(k), 16'h0100 + 16'(k), 3'd0, 16'h0200 + 16'(k), 3'd0);
            step();
        end
        issue(16'h00FF, 16'd0, 3'd0, 16'd0, 3'd0);
        @(negedge clk); chk("full ready", issue_ready, 0); chk("full busy", busy_count, 3);
        step(); issue_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); chk("held pulse", fu_pulse, 0); chk("held busy", busy_count, 3);
            step();
        end
        fu_disp = 1'b1;
        @(negedge clk); chk("rise nopulse", fu_pulse, 0);
        step();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("drain pulse", fu_pulse, 1); chk("drain code", fu_code, 1 + k);
            chk("drain reg2", fu_reg2, 16'h0100 + 16'(k));
            step();
            @(negedge clk); chk("drain gap", fu_pulse, 0);
            step();
        end
        fu_disp = 1'b0;

        // Issue during a broadcast of the awaited tag
        issue(16'h0002, 16'd1, 3'd0, 16'h5555, 3'd3);
        cdb_valid = 1'b1; cdb_tag = 3'd3; cdb_data = 16'h00AA;
        @(negedge clk);
`ifdef RS_CDB_BYPASS_EN
        chk("byp ready", issue_ready, 1);
`else
        chk("byp ready", issue_ready, 0);
`endif
        step(); issue_valid = 1'b0; cdb_valid = 1'b0; fu_disp = 1'b1;
        @(negedge clk);
`ifdef RS_CDB_BYPASS_EN
        chk("byp busy", busy_count, 1);
        step();
        @(negedge clk); chk("byp pulse", fu_pulse, 1); chk("byp reg1", fu_reg1, 16'h00AA);
`else
        chk("byp busy", busy_count, 0);
        step();
        @(negedge clk); chk("byp pulse", fu_pulse, 0);
`endif
        step(); step();

        // Reset with entries busy and a pulse on the output
        fu_disp = 1'b0;
        for (int k = 0; k < 3; k++) begin
            issue(16'h0020 + 16'(k), 16'd7, 3'd0, 16'd8, 3'd0);
            step();
        end
        issue_valid = 1'b0; fu_disp = 1'b1;
        step();
        @(negedge clk); chk("pre-rst pulse", fu_pulse, 1); chk("pre-rst busy", busy_count, 2);
        #2 rst = 1'b1;
        #1;
        chk("rst pulse cleared", fu_pulse, 0);
        chk("rst busy cleared", busy_count, 0);
        chk("rst issue_ready", issue_ready, 1);
        @(posedge clk); step();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); chk("post-rst nopulse", fu_pulse, 0);
            step();
        end

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            issue_valid = ($urandom_range(0, 1) == 1);
            issue_inst  = 16'($urandom);
            issue_vj    = 16'($urandom);
            issue_vk    = 16'($urandom);
            issue_qj    = ($urandom_range(0, 1) == 1) ? 3'($urandom_range(1, 4)) : 3'd0;
            issue_qk    = ($urandom_range(0, 1) == 1) ? 3'($urandom_range(1, 4)) : 3'd0;
            cdb_valid   = ($urandom_range(0, 9) < 4);
            cdb_tag     = 3'($urandom_range(0, 5));
            cdb_data    = 16'($urandom);
            fu_disp     = ($urandom_range(0, 9) < 7);
            step();
        end

        issue_valid = 1'b0; cdb_valid = 1'b0;
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
